serial_frame_tx: RTL and testbench
==================================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles each line bit is held (minimum 2).
REQ-003 The block SHALL have parameter PARITY_EN, default 1, meaning 1 inserts an even-parity bit and 0 omits it.
REQ-004 Port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-005 Port rstn, input, 1 bit: synchronous active-low reset.
REQ-006 Port tx_data, input, DATA_W bits: payload to send, sampled only at acceptance.
REQ-007 Port tx_valid, input, 1 bit: requester has a payload.
REQ-008 Port tx_ready, output, 1 bit: block can accept a payload this cycle.
REQ-009 Port tx_line, output, 1 bit: registered serial line, idle high, intended to be sampled by the downstream d_ff capture stage.
REQ-010 Port tx_busy, output, 1 bit: frame in progress.
REQ-011 Port tx_done, output, 1 bit: one-cycle pulse on frame completion.

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; PARITY SHALL be skipped when PARITY_EN=0.
REQ-013 tx_ready SHALL be 1 only in IDLE, and acceptance SHALL occur on a rising edge where tx_valid && tx_ready.
REQ-014 On acceptance the block SHALL latch tx_data into a shift register, compute even parity (XOR of all bits), enter START and clear the bit counter.
REQ-015 tx_line SHALL be 0 in START, shift-register bit 0 (LSB first) in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-016 Each state bit SHALL last exactly CLKS_PER_BIT cycles, timed by a cycle counter that wraps 0..CLKS_PER_BIT-1 and produces a bit_tick on its terminal count.
REQ-017 In DATA, each bit_tick SHALL shift the register right by 1, and DATA SHALL exit after DATA_W ticks.
REQ-018 Transition sequence: IDLE->START on accept; START->DATA, DATA->PARITY (or STOP), PARITY->STOP on bit_tick; STOP->IDLE on bit_tick.
REQ-019 Latency: tx_line SHALL go low on the edge after the acceptance edge, and the frame length SHALL be (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles (44 with defaults).
REQ-020 tx_done SHALL be 1 for exactly the first IDLE cycle after STOP, coincident with tx_ready=1.
REQ-021 With tx_valid held high, the next frame SHALL be accepted in that same first IDLE cycle, giving zero extra gap beyond the stop bit.
REQ-022 tx_data and tx_valid changes while tx_busy=1 SHALL have no effect on the frame in flight.
REQ-023 tx_busy SHALL equal (state != IDLE).

Reset
REQ-024 While rstn=0 at a rising edge, the block SHALL set state=IDLE, tx_line=1, tx_ready=1, tx_busy=0, tx_done=0, and clear the counters and shift register.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no tx_done, and the line SHALL be high from the next edge.
REQ-026 A tx_valid present during the reset cycle SHALL NOT be accepted.

Structure
REQ-027 Package serial_frame_pkg SHALL hold the state enum typedef and the default DATA_W/CLKS_PER_BIT/PARITY_EN constants.
REQ-028 One sub-module, bit_timer (clk, rstn, clear, bit_tick), SHALL implement the CLKS_PER_BIT counter.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to tx_line.

Verification
REQ-030 Defaults, send 0xA5 -> tx_line per 4-cycle bit: 0,1,0,1,0,0,1,0,1,0(parity),1; tx_done at cycle 45 after accept.
REQ-031 Send 0x01 -> parity bit 1; send 0x00 -> parity bit 0, data bits all 0.
REQ-032 tx_valid held high with 0x3C then 0xC3 -> second start bit immediately follows the first stop bit, with tx_ready high for exactly 1 cycle.
REQ-033 Drop rstn for one edge mid-DATA -> tx_line=1, tx_busy=0, no tx_done; a new frame is accepted cleanly afterwards.
REQ-034 PARITY_EN=0, CLKS_PER_BIT=2, send 0xFF -> frame of 20 cycles with no parity bit.
REQ-035 Toggle tx_data during a frame -> transmitted bits match the value latched at acceptance.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter: FSM state encoding
// and the default frame geometry used by the top and its bit timer.
package serial_frame_pkg;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 4;
    localparam int DEF_PARITY_EN    = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each line bit so the FSM advances exactly once per bit period.
module bit_timer
    import serial_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] r_count;

    // The tick is the terminal count of the wrapping counter.
    assign bit_tick = (r_count == CW'(CLKS_PER_BIT - 1));

    // Cycle counter; held at zero while cleared so a new frame starts aligned.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            r_count <= '0;
        end else if (bit_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LSB-first payload, optional even
// parity bit, stop bit. Every output is a register so the downstream
// capture flop sees a glitch-free line.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = DEF_PARITY_EN
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_line,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shreg;
    logic              r_parity;
    logic [BW-1:0]     r_bitCnt;
    logic              r_line;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;

    logic              w_bitTick;
    logic              w_timerClear;
    logic [DATA_W-1:0] w_shNext;

    // Timer idles at zero between frames so START gets a full bit period.
    assign w_timerClear = (r_state == IDLE);
    assign w_shNext     = r_shreg >> 1;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (w_timerClear),
        .bit_tick (w_bitTick)
    );

    // Frame sequencer; line, ready, busy and done are set alongside the
    // state they belong to so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_parity <= 1'b0;
            r_bitCnt <= '0;
            r_line   <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_shreg  <= tx_data;
                        r_parity <= ^tx_data;
                        r_bitCnt <= '0;
                        r_state  <= START;
                        r_line   <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (w_bitTick) begin
                        r_state <= DATA;
                        r_line  <= r_shreg[0];
                    end
                end
                DATA: begin
                    if (w_bitTick) begin
                        r_shreg <= w_shNext;
                        if (r_bitCnt == BW'(DATA_W - 1)) begin
                            r_bitCnt <= '0;
                            if (PARITY_EN != 0) begin
                                r_state <= PARITY;
                                r_line  <= r_parity;
                            end else begin
                                r_state <= STOP;
                                r_line  <= 1'b1;
                            end
                        end else begin
                            r_bitCnt <= r_bitCnt + BW'(1);
                            r_line   <= w_shNext[0];
                        end
                    end
                end
                PARITY: begin
                    if (w_bitTick) begin
                        r_state <= STOP;
                        r_line  <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_bitTick) begin
                        r_state <= IDLE;
                        r_line  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_line  <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = r_ready;
    assign tx_line  = r_line;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: a default instance (8 data bits,
// 4 clocks per bit, parity) and a short-bit instance without parity.
module tb_serial_frame_tx;

    logic       clk;
    logic       rstn;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic       txLine;
    logic       txBusy;
    logic       txDone;
    logic [7:0] txData2;
    logic       txValid2;
    logic       txReady2;
    logic       txLine2;
    logic       txBusy2;
    logic       txDone2;

    int checkCount = 0;
    int passCount  = 0;

    logic lineLog  [0:127];
    logic readyLog [0:127];
    logic busyLog  [0:127];
    logic doneLog  [0:127];

    serial_frame_tx dut (
        .clk      (clk),
        .rstn     (rstn),
        .tx_data  (txData),
        .tx_valid (txValid),
        .tx_ready (txReady),
        .tx_line  (txLine),
        .tx_busy  (txBusy),
        .tx_done  (txDone)
    );

    serial_frame_tx #(
        .DATA_W       (8),
        .CLKS_PER_BIT (2),
        .PARITY_EN    (0)
    ) dut2 (
        .clk      (clk),
        .rstn     (rstn),
        .tx_data  (txData2),
        .tx_valid (txValid2),
        .tx_ready (txReady2),
        .tx_line  (txLine2),
        .tx_busy  (txBusy2),
        .tx_done  (txDone2)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Record n cycles of outputs (sampled on falling edges) into the logs;
    // cycle 1 is the cycle right after the edge that preceded the call.
    task automatic logCycles(input int n, input int dutSel, input bit scramble,
                             input int dropValidAt);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == dropValidAt) begin
                txValid  = 1'b0;
                txValid2 = 1'b0;
            end
            if (scramble) begin
                txData = 8'($urandom);
            end
            lineLog[c]  = (dutSel == 0) ? txLine  : txLine2;
            readyLog[c] = (dutSel == 0) ? txReady : txReady2;
            busyLog[c]  = (dutSel == 0) ? txBusy  : txBusy2;
            doneLog[c]  = (dutSel == 0) ? txDone  : txDone2;
        end
    endtask

    // Present a payload and return just after the edge that accepts it.
    task automatic applyStimulus(input int dutSel, input logic [7:0] data);
        @(negedge clk);
        if (dutSel == 0) begin
            txData  = data;
            txValid = 1'b1;
        end else begin
            txData2  = data;
            txValid2 = 1'b1;
        end
        @(posedge clk);
        #1;
        txValid  = 1'b0;
        txValid2 = 1'b0;
    endtask

    // Line value of each frame bit at its first (or last) cycle.
    function automatic logic [15:0] sampleBits(int base, int nBits, int cpb, bit useLast);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < nBits; i++) begin
            r[i] = lineLog[base + i * cpb + (useLast ? cpb : 1)];
        end
        return r;
    endfunction

    function automatic int firstDone(int from, int to);
        for (int c = from; c <= to; c++) begin
            if (doneLog[c]) return c;
        end
        return -1;
    endfunction

    function automatic int countHigh(int from, int to, int which);
        int n;
        n = 0;
        for (int c = from; c <= to; c++) begin
            if (which == 0 && doneLog[c])  n++;
            if (which == 1 && busyLog[c])  n++;
            if (which == 2 && readyLog[c]) n++;
        end
        return n;
    endfunction

    initial begin
        rstn     = 1'b0;
        txData   = 8'h00;
        txValid  = 1'b1;
        txData2  = 8'h00;
        txValid2 = 1'b1;

        // Reset with a pending request that must not be taken.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_line",  32'(txLine),  32'd1);
        checkOutput("rst_ready", 32'(txReady), 32'd1);
        checkOutput("rst_busy",  32'(txBusy),  32'd0);
        checkOutput("rst_done",  32'(txDone),  32'd0);
        checkOutput("rst2_line", 32'(txLine2), 32'd1);
        checkOutput("rst2_busy", 32'(txBusy2), 32'd0);
        txValid  = 1'b0;
        txValid2 = 1'b0;
        rstn     = 1'b1;

        // 0xA5: frame 0,1,0,1,0,0,1,0,1,parity 0,stop 1.
        applyStimulus(0, 8'hA5);
        logCycles(52, 0, 1'b0, 0);
        checkOutput("a5_bits_first", 32'(sampleBits(0, 11, 4, 1'b0)), 32'h054A);
        checkOutput("a5_bits_last",  32'(sampleBits(0, 11, 4, 1'b1)), 32'h054A);
        checkOutput("a5_done_cycle", 32'(firstDone(1, 52)), 32'd45);
        checkOutput("a5_done_count", 32'(countHigh(1, 52, 0)), 32'd1);
        checkOutput("a5_busy_c44",   32'(busyLog[44]), 32'd1);
        checkOutput("a5_busy_c45",   32'(busyLog[45]), 32'd0);
        checkOutput("a5_ready_c45",  32'(readyLog[45]), 32'd1);
        checkOutput("a5_ready_c1",   32'(readyLog[1]), 32'd0);

        // 0x01 has odd weight so the parity bit is 1.
        applyStimulus(0, 8'h01);
        logCycles(48, 0, 1'b0, 0);
        checkOutput("x01_bits",      32'(sampleBits(0, 11, 4, 1'b0)), 32'h0602);
        checkOutput("x01_done_cycle", 32'(firstDone(1, 48)), 32'd45);

        // 0x00: only the stop bit is high.
        applyStimulus(0, 8'h00);
        logCycles(48, 0, 1'b0, 0);
        checkOutput("x00_bits_first", 32'(sampleBits(0, 11, 4, 1'b0)), 32'h0400);
        checkOutput("x00_bits_last",  32'(sampleBits(0, 11, 4, 1'b1)), 32'h0400);

        // Back-to-back: valid held, second payload taken in first IDLE cycle.
        @(negedge clk);
        txData  = 8'h3C;
        txValid = 1'b1;
        @(posedge clk);
        #1;
        txData = 8'hC3;
        logCycles(100, 0, 1'b0, 46);
        checkOutput("b2b_f1_bits",     32'(sampleBits(0, 11, 4, 1'b0)), 32'h0478);
        checkOutput("b2b_f2_bits",     32'(sampleBits(45, 11, 4, 1'b0)), 32'h0586);
        checkOutput("b2b_line_c45",    32'(lineLog[45]), 32'd1);
        checkOutput("b2b_line_c46",    32'(lineLog[46]), 32'd0);
        checkOutput("b2b_ready_count", 32'(countHigh(1, 89, 2)), 32'd1);
        checkOutput("b2b_ready_c45",   32'(readyLog[45]), 32'd1);
        checkOutput("b2b_done_count",  32'(countHigh(1, 100, 0)), 32'd2);
        checkOutput("b2b_done2_cycle", 32'(firstDone(46, 100)), 32'd90);

        // Reset pulse mid-DATA with a request pending: frame aborts silently.
        applyStimulus(0, 8'hA5);
        logCycles(10, 0, 1'b0, 0);
        rstn    = 1'b0;
        txValid = 1'b1;
        txData  = 8'h77;
        @(negedge clk);
        checkOutput("abort_line",  32'(txLine),  32'd1);
        checkOutput("abort_busy",  32'(txBusy),  32'd0);
        checkOutput("abort_ready", 32'(txReady), 32'd1);
        checkOutput("abort_done",  32'(txDone),  32'd0);
        rstn    = 1'b1;
        txValid = 1'b0;
        logCycles(50, 0, 1'b0, 0);
        checkOutput("abort_no_done", 32'(countHigh(1, 50, 0)), 32'd0);
        checkOutput("abort_no_busy", 32'(countHigh(1, 50, 1)), 32'd0);
        applyStimulus(0, 8'h01);
        logCycles(48, 0, 1'b0, 0);
        checkOutput("after_abort_bits", 32'(sampleBits(0, 11, 4, 1'b0)), 32'h0602);
        checkOutput("after_abort_done", 32'(firstDone(1, 48)), 32'd45);

        // Payload input scrambled mid-frame must not leak into the line.
        applyStimulus(0, 8'h5A);
        logCycles(48, 0, 1'b1, 0);
        checkOutput("scramble_bits_first", 32'(sampleBits(0, 11, 4, 1'b0)), 32'h04B4);
        checkOutput("scramble_bits_last",  32'(sampleBits(0, 11, 4, 1'b1)), 32'h04B4);

        // No parity, 2 clocks per bit: 0xFF gives a 20-cycle, 10-bit frame.
        applyStimulus(1, 8'hFF);
        logCycles(26, 1, 1'b0, 0);
        checkOutput("np_bits_first", 32'(sampleBits(0, 10, 2, 1'b0)), 32'h03FE);
        checkOutput("np_bits_last",  32'(sampleBits(0, 10, 2, 1'b1)), 32'h03FE);
        checkOutput("np_done_cycle", 32'(firstDone(1, 26)), 32'd21);
        checkOutput("np_busy_c20",   32'(busyLog[20]), 32'd1);
        checkOutput("np_busy_c21",   32'(busyLog[21]), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
